// File: rtl/seg7_scan_mux_if.sv
// Bus bundle for the 7-segment scan multiplexer: control/data in, display drive out.
// Handshake: load is a single-cycle strobe sampled on the rising clock edge; there is
// no ready/backpressure, the scanner accepts every strobe. Outputs are registered.
interface seg7_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  en;
    logic                  load;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [3:0]            hex;
    logic [N_DIGITS-1:0]   an_n;
    logic                  dp_n;
    logic                  blank;
    logic [IDX_W-1:0]      digit_idx;

    // Driver side (board logic / testbench)
    modport master (
        output en, load, value, dp_in,
        input  hex, an_n, dp_n, blank, digit_idx
    );

    // Scanner side
    modport slave (
        input  en, load, value, dp_in,
        output hex, an_n, dp_n, blank, digit_idx
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// A prescaler divides clk into digit slots; each slot starts with a short anode-off
// guard period so the previous digit's segments never ghost onto the next anode.
module seg7_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_mux_if.slave     bus
);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYC + 1);

    logic [4*N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]   r_dp;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DEAD_W-1:0]     r_dead;

    logic [3:0]            r_hex;
    logic [N_DIGITS-1:0]   r_an_n;
    logic                  r_dp_n;
    logic                  r_blank;
    logic [IDX_W-1:0]      r_digit_idx;

    logic                  w_tick;
    logic                  w_zero_run;
    logic [N_DIGITS-1:0]   w_lz;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_dp;
    logic                  w_cur_lz;
    logic [N_DIGITS-1:0]   w_sel;

    assign w_tick = bus.en && (r_cnt == CNT_W'(CLK_DIV - 1));

    // Shadow capture: a load strobe is honoured whether or not scanning is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_dp     <= '0;
        end else if (bus.load) begin
            r_shadow <= bus.value;
            r_dp     <= bus.dp_in;
        end
    end

    // Slot timing: prescaler, digit index and guard counter, all frozen while en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_dead <= DEAD_W'(DEAD_CYC);
        end else if (bus.en) begin
            if (w_tick) begin
                r_cnt  <= '0;
                r_idx  <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                r_dead <= DEAD_W'(DEAD_CYC);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_dead != '0) begin
                    r_dead <= r_dead - DEAD_W'(1);
                end
            end
        end
    end

    // Leading-zero flags: digit i is blank when it and every digit above it are zero
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_shadow[4*i +: 4] == 4'h0);
            w_lz[i]    = (BLANK_LZ != 0) && (i > 0) && w_zero_run;
        end
    end

    // Select nibble, decimal point and blank flag of the digit in the current slot
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_dp  = 1'b0;
        w_cur_lz  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_nib = r_shadow[4*i +: 4];
                w_cur_dp  = r_dp[i];
                w_cur_lz  = w_lz[i];
            end
        end
    end

    assign w_sel = N_DIGITS'(1) << r_idx;

    // Registered display drive; reset darkens the anodes without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex       <= 4'h0;
            r_an_n      <= '1;
            r_dp_n      <= 1'b1;
            r_blank     <= 1'b0;
            r_digit_idx <= '0;
        end else begin
            r_hex       <= w_cur_nib;
            r_dp_n      <= ~w_cur_dp;
            r_blank     <= w_cur_lz;
            r_digit_idx <= r_idx;
            r_an_n      <= (bus.en && (r_dead == '0) && !w_cur_lz) ? ~w_sel : '1;
        end
    end

    assign bus.hex       = r_hex;
    assign bus.an_n      = r_an_n;
    assign bus.dp_n      = r_dp_n;
    assign bus.blank     = r_blank;
    assign bus.digit_idx = r_digit_idx;

endmodule
